// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU: opcode encoding, FSM states and
// the mul/div opcode classifier.
package alu_pkg;

    localparam int unsigned OP_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_SLL   = 5'd0,
        OP_SRA   = 5'd1,
        OP_SRL   = 5'd2,
        OP_ADD   = 5'd3,
        OP_SUB   = 5'd4,
        OP_AND   = 5'd5,
        OP_OR    = 5'd6,
        OP_XOR   = 5'd7,
        OP_NOR   = 5'd8,
        OP_CMP   = 5'd9,
        OP_CMPU  = 5'd10,
        OP_MULT  = 5'd16,
        OP_MULTU = 5'd17,
        OP_DIV   = 5'd18,
        OP_DIVU  = 5'd19,
        OP_MFHI  = 5'd20,
        OP_MFLO  = 5'd21,
        OP_MTHI  = 5'd22,
        OP_MTLO  = 5'd23
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    // True for the four iterative opcodes that occupy md_iter.
    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_iter.sv
// Iterative multiply / restoring divide over a shared 2*WIDTH accumulator.
// One bit per clock, WIDTH steps; the first step is taken on the start edge,
// so o_done_c rises in the WIDTH-th cycle after start.
// Operands are made unsigned first; the sign is restored on the way out.
// Ports:
//   clk, rst            clock, async active-high reset
//   i_flush             abandon the running operation
//   i_start             load operands and begin (one-cycle pulse)
//   i_is_div            1 = divide, 0 = multiply
//   i_is_signed         treat operands as two's complement
//   i_a, i_b            multiplicand/dividend, multiplier/divisor
//   o_done_c            result valid on o_hi_c/o_lo_c this cycle
//   o_hi_c, o_lo_c      product high/low or remainder/quotient
module md_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_start,
    input  logic             i_is_div,
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done_c,
    output logic [WIDTH-1:0] o_hi_c,
    output logic [WIDTH-1:0] o_lo_c
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned AW  = 2 * WIDTH;

    logic             r_run;
    logic [SHW-1:0]   r_cnt;
    logic [AW-1:0]    r_acc;
    logic [WIDTH-1:0] r_opb;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div0;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [AW-1:0]    w_src_acc;
    logic [WIDTH-1:0] w_src_b;
    logic             w_src_div;
    logic [WIDTH:0]   w_mul_sum;
    logic [AW-1:0]    w_mul_next;
    logic [WIDTH:0]   w_div_r;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_ge;
    logic [AW-1:0]    w_div_next;
    logic [AW-1:0]    w_step;
    logic [AW-1:0]    w_prod;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    // Sign pre-correction.
    assign w_a_neg = i_is_signed & i_a[WIDTH-1];
    assign w_b_neg = i_is_signed & i_b[WIDTH-1];
    assign w_a_abs = w_a_neg ? (~i_a + WIDTH'(1)) : i_a;
    assign w_b_abs = w_b_neg ? (~i_b + WIDTH'(1)) : i_b;

    // On the start edge the step operates on the freshly prepared operands.
    assign w_src_acc = i_start ? {WIDTH'(0), w_a_abs} : r_acc;
    assign w_src_b   = i_start ? w_b_abs : r_opb;
    assign w_src_div = i_start ? i_is_div : r_is_div;

    // Shift-add: conditionally add into the high half, then shift right with carry.
    assign w_mul_sum  = {1'b0, w_src_acc[AW-1:WIDTH]} +
                        (w_src_acc[0] ? {1'b0, w_src_b} : (WIDTH+1)'(0));
    assign w_mul_next = {w_mul_sum, w_src_acc[WIDTH-1:1]};

    // Restoring divide: shift one dividend bit into the remainder, trial-subtract.
    assign w_div_r    = w_src_acc[AW-1:WIDTH-1];
    assign w_div_diff = w_div_r - {1'b0, w_src_b};
    assign w_div_ge   = ~w_div_diff[WIDTH];
    assign w_div_next = {(w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_r[WIDTH-1:0]),
                         w_src_acc[WIDTH-2:0], w_div_ge};

    assign w_step = w_src_div ? w_div_next : w_mul_next;

    // Iteration state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
        end else if (i_flush) begin
            r_run <= 1'b0;
        end else if (i_start) begin
            r_run    <= 1'b1;
            r_cnt    <= SHW'(WIDTH - 1);
            r_acc    <= w_step;
            r_opb    <= w_b_abs;
            r_is_div <= i_is_div;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= i_is_div && (i_b == '0);
        end else if (r_run) begin
            if (r_cnt == '0) begin
                r_run <= 1'b0;
            end else begin
                r_acc <= w_step;
                r_cnt <= r_cnt - SHW'(1);
            end
        end
    end

    // Sign post-correction. A zero divisor leaves quotient all-ones and the
    // remainder equal to the dividend, so only the remainder gets its sign back.
    assign w_prod = r_neg_q ? (~r_acc + AW'(1)) : r_acc;
    assign w_quo  = (r_neg_q && !r_div0) ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? (~r_acc[AW-1:WIDTH] + WIDTH'(1)) : r_acc[AW-1:WIDTH];

    assign o_done_c = r_run && (r_cnt == '0);
    assign o_hi_c   = r_is_div ? w_rem : w_prod[AW-1:WIDTH];
    assign o_lo_c   = r_is_div ? w_quo : w_prod[WIDTH-1:0];

endmodule

// File: rtl/alu_md.sv
// EX-stage integer ALU with registered result, valid/ready handshake,
// HI/LO registers and an iterative multiply/divide unit.
// Ports:
//   clk, rst             clock, async active-high reset
//   flush                cancel any in-flight op, block accept this cycle
//   in_valid / in_ready  op handshake (in_ready combinational)
//   op, in1, in2         opcode and operands
//   out_valid/out_ready  result handshake
//   out, equal, ovf      result, (in1==in2) of the op, signed ADD/SUB overflow
//   busy                 multiply/divide in progress
module alu_md
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             equal,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned SHW = $clog2(WIDTH);

    state_e           r_state;
    state_e           w_next_state;
    logic [WIDTH-1:0] r_out;
    logic             r_equal;
    logic             r_ovf;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic             w_md_start;
    logic             w_md_div;
    logic             w_md_signed;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ovf;
    logic             w_md_done_c;
    logic [WIDTH-1:0] w_md_hi_c;
    logic [WIDTH-1:0] w_md_lo_c;

    // Handshake and mul/div dispatch.
    assign in_ready    = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && in_ready && !flush;
    assign w_md_start  = w_accept && is_muldiv(op);
    assign w_md_div    = (op == OP_DIV)  || (op == OP_DIVU);
    assign w_md_signed = (op == OP_MULT) || (op == OP_DIV);

    assign w_shamt = in2[SHW-1:0];
    assign w_sum   = in1 + in2;
    assign w_diff  = in1 - in2;

    // Single-cycle result and overflow.
    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (op)
            OP_SLL:  w_alu_res = in1 << w_shamt;
            OP_SRA:  w_alu_res = $signed(in1) >>> w_shamt;
            OP_SRL:  w_alu_res = in1 >> w_shamt;
            OP_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (w_sum[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (w_diff[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_AND:  w_alu_res = in1 & in2;
            OP_OR:   w_alu_res = in1 | in2;
            OP_XOR:  w_alu_res = in1 ^ in2;
            OP_NOR:  w_alu_res = ~(in1 | in2);
            OP_CMP:  w_alu_res = WIDTH'($signed(in1) < $signed(in2));
            OP_CMPU: w_alu_res = WIDTH'(in1 < in2);
            OP_MFHI: w_alu_res = r_hi;
            OP_MFLO: w_alu_res = r_lo;
            OP_MTHI: w_alu_res = in1;
            OP_MTLO: w_alu_res = in1;
            default: w_alu_res = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state.
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_md_start) begin
                        w_next_state = w_md_div ? ST_DIV : ST_MUL;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (w_md_done_c) begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // Result register, flags and HI/LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= '0;
            r_equal     <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_equal <= (in1 == in2);
                if (w_md_start) begin
                    r_ovf <= 1'b0;
                end else begin
                    r_out       <= w_alu_res;
                    r_ovf       <= w_alu_ovf;
                    r_out_valid <= 1'b1;
                    if (op == OP_MTHI) r_hi <= in1;
                    if (op == OP_MTLO) r_lo <= in1;
                end
            end
            if (w_md_done_c) begin
                r_hi        <= w_md_hi_c;
                r_lo        <= w_md_lo_c;
                r_out       <= w_md_lo_c;
                r_out_valid <= 1'b1;
            end
        end
    end

    md_iter #(
        .WIDTH (WIDTH)
    ) u_md_iter (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (flush),
        .i_start     (w_md_start),
        .i_is_div    (w_md_div),
        .i_is_signed (w_md_signed),
        .i_a         (in1),
        .i_b         (in2),
        .o_done_c    (w_md_done_c),
        .o_hi_c      (w_md_hi_c),
        .o_lo_c      (w_md_lo_c)
    );

    assign out       = r_out;
    assign equal     = r_equal;
    assign ovf       = r_ovf;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md (WIDTH=32) against an arithmetic reference model.
module tb_alu_md;

    localparam longint MAXI = 64'sh7fffffff;
    localparam longint MINI = -64'sh80000000;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        equal;
    logic        ovf;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    alu_md #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .equal     (equal),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: result, overflow, latency, and HI/LO side effects.
    task automatic ref_model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] r, output logic v, output int lat);
        longint      s;
        logic [63:0] p;
        r   = 32'h0;
        v   = 1'b0;
        lat = 1;
        case (o)
            5'd0:  r = a << b[4:0];
            5'd1:  r = $signed(a) >>> b[4:0];
            5'd2:  r = a >> b[4:0];
            5'd3: begin
                s = longint'($signed(a)) + longint'($signed(b));
                r = a + b;
                v = (s > MAXI) || (s < MINI);
            end
            5'd4: begin
                s = longint'($signed(a)) - longint'($signed(b));
                r = a - b;
                v = (s > MAXI) || (s < MINI);
            end
            5'd5:  r = a & b;
            5'd6:  r = a | b;
            5'd7:  r = a ^ b;
            5'd8:  r = ~(a | b);
            5'd9:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd10: r = (a < b) ? 32'd1 : 32'd0;
            5'd16: begin
                s = longint'($signed(a)) * longint'($signed(b));
                p = s;
                m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; lat = 33;
            end
            5'd17: begin
                p = {32'h0, a} * {32'h0, b};
                m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; lat = 33;
            end
            5'd18: begin
                if (b == 32'h0) begin
                    m_lo = 32'hffffffff; m_hi = a;
                end else begin
                    s = longint'($signed(a)) / longint'($signed(b));
                    p = s; m_lo = p[31:0];
                    s = longint'($signed(a)) % longint'($signed(b));
                    p = s; m_hi = p[31:0];
                end
                r = m_lo; lat = 33;
            end
            5'd19: begin
                if (b == 32'h0) begin
                    m_lo = 32'hffffffff; m_hi = a;
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
                r = m_lo; lat = 33;
            end
            5'd20: r = m_hi;
            5'd21: r = m_lo;
            5'd22: begin m_hi = a; r = a; end
            5'd23: begin m_lo = a; r = a; end
            default: r = 32'h0;
        endcase
    endtask

    // Present one op with out_ready=1 and wait (bounded) for its result.
    task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic e, output logic v,
                          output int lat, output int bcyc,
                          output logic [31:0] xr, output logic xv, output int xlat);
        int g;
        ref_model(o, a, b, xr, xv, xlat);
        @(negedge clk);
        in_valid  = 1'b1;
        op        = o;
        in1       = a;
        in2       = b;
        out_ready = 1'b1;
        g = 0;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        lat  = 0;
        bcyc = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            if (busy && !in_ready) bcyc++;
        end while (!out_valid && lat < 100);
        r = out;
        e = equal;
        v = ovf;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = 5'd0;
        in1 = 32'h0; in2 = 32'h0; out_ready = 1'b0;
        m_hi = 32'h0; m_lo = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({out_valid, busy, equal, ovf} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got %b want 0000", {out_valid, busy, equal, ovf});
        end
        total++;
        if (out !== 32'h0) begin bad++; $display("FAIL reset_out got %h want 0", out); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_hilo_reset();
        logic [31:0] r, xr; logic e, v, xv; int lat, bc, xl;
        run_op(5'd20, 32'h0, 32'h0, r, e, v, lat, bc, xr, xv, xl);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL reset_hi got %h want 0", r); end
        run_op(5'd21, 32'h0, 32'h0, r, e, v, lat, bc, xr, xv, xl);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL reset_lo got %h want 0", r); end
    endtask

    task automatic test_add_ovf();
        logic [31:0] r, xr; logic e, v, xv; int lat, bc, xl;
        run_op(5'd3, 32'h7fffffff, 32'h1, r, e, v, lat, bc, xr, xv, xl);
        total++;
        if (r !== 32'h80000000) begin bad++; $display("FAIL add_out got %h want 80000000", r); end
        total++;
        if ({v, e} !== 2'b10) begin bad++; $display("FAIL add_flags ovf,equal got %b want 10", {v, e}); end
        total++;
        if (lat !== 1) begin bad++; $display("FAIL add_latency got %0d want 1", lat); end
    endtask

    task automatic test_mult();
        logic [31:0] r, xr; logic e, v, xv; int lat, bc, xl;
        run_op(5'd16, 32'hfffffffd, 32'd5, r, e, v, lat, bc, xr, xv, xl);
        total++;
        if (r !== 32'hfffffff1) begin bad++; $display("FAIL mult_lo got %h want fffffff1", r); end
        total++;
        if (bc !== 32) begin bad++; $display("FAIL mult_busy_cycles got %0d want 32", bc); end
        total++;
        if (lat !== 33) begin bad++; $display("FAIL mult_latency got %0d want 33", lat); end
        run_op(5'd20, 32'h0, 32'h0, r, e, v, lat, bc, xr, xv, xl);
        total++;
        if (r !== 32'hffffffff) begin bad++; $display("FAIL mult_hi got %h want ffffffff", r); end
    endtask

    task automatic test_div();
        logic [31:0] r, xr; logic e, v, xv; int lat, bc, xl;
        logic [4:0]  dop [3] = '{5'd18, 5'd19, 5'd18};
        logic [31:0] da  [3] = '{32'hfffffff9, 32'd7, 32'h80000000};
        logic [31:0] db  [3] = '{32'd2, 32'd0, 32'hffffffff};
        logic [31:0] elo [3] = '{32'hfffffffd, 32'hffffffff, 32'h80000000};
        logic [31:0] ehi [3] = '{32'hffffffff, 32'h7, 32'h0};
        for (int i = 0; i < 3; i++) begin
            run_op(dop[i], da[i], db[i], r, e, v, lat, bc, xr, xv, xl);
            total++;
            if (r !== elo[i] || lat !== 33) begin
                bad++; $display("FAIL div_lo[%0d] got %h lat %0d want %h lat 33", i, r, lat, elo[i]);
            end
            run_op(5'd20, 32'h0, 32'h0, r, e, v, lat, bc, xr, xv, xl);
            total++;
            if (r !== ehi[i]) begin bad++; $display("FAIL div_hi[%0d] got %h want %h", i, r, ehi[i]); end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        in_valid = 1'b1; op = 5'd4; in1 = 32'd5; in2 = 32'd7; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        op = 5'd3; in1 = 32'd2; in2 = 32'd3;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out !== 32'hfffffffe || out_valid !== 1'b1 || in_ready !== 1'b0 || equal !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d] out %h v %b rdy %b eq %b want fffffffe 1 0 0",
                         i, out, out_valid, in_ready, equal);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out !== 32'd5) begin
            bad++; $display("FAIL bp_next_op out %h v %b want 00000005 1", out, out_valid);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        logic [31:0] r, xr; logic e, v, xv; int lat, bc, xl;
        int n, g;
        logic rose;
        run_op(5'd22, 32'h1234, 32'h0, r, e, v, lat, bc, xr, xv, xl);
        total++;
        if (r !== 32'h1234) begin bad++; $display("FAIL mthi_out got %h want 00001234", r); end
        @(negedge clk);
        in_valid = 1'b1; op = 5'd19; in1 = 32'd100; in2 = 32'd3;
        @(posedge clk);
        n = 0; g = 0;
        while (n < 10 && g < 100) begin
            @(negedge clk);
            in_valid = 1'b0;
            g++;
            if (busy) n++;
        end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_abort busy %b v %b rdy %b want 0 0 1", busy, out_valid, in_ready);
        end
        rose = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) rose = 1'b1;
        end
        total++;
        if (rose !== 1'b0) begin bad++; $display("FAIL flush_no_result got %b want 0", rose); end
        run_op(5'd20, 32'h0, 32'h0, r, e, v, lat, bc, xr, xv, xl);
        total++;
        if (r !== 32'h1234) begin bad++; $display("FAIL flush_hi got %h want 00001234", r); end
        run_op(5'd21, 32'h0, 32'h0, r, e, v, lat, bc, xr, xv, xl);
        total++;
        if (r !== xr) begin bad++; $display("FAIL flush_lo got %h want %h", r, xr); end
    endtask

    task automatic test_reset_mid_mult();
        logic [31:0] r, xr; logic e, v, xv; int lat, bc, xl;
        run_op(5'd22, 32'haaaa5555, 32'h0, r, e, v, lat, bc, xr, xv, xl);
        run_op(5'd23, 32'h5555aaaa, 32'h0, r, e, v, lat, bc, xr, xv, xl);
        run_op(5'd3, 32'd1, 32'd2, r, e, v, lat, bc, xr, xv, xl);
        @(negedge clk);
        in_valid = 1'b1; op = 5'd16; in1 = 32'd7; in2 = 32'd9;
        @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        total++;
        if (out !== 32'h0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL async_rst out %h v %b busy %b want 0 0 0", out, out_valid, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        m_hi = 32'h0; m_lo = 32'h0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL async_rst_ready got %b want 1", in_ready); end
        run_op(5'd20, 32'h0, 32'h0, r, e, v, lat, bc, xr, xv, xl);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL async_rst_hi got %h want 0", r); end
        run_op(5'd21, 32'h0, 32'h0, r, e, v, lat, bc, xr, xv, xl);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL async_rst_lo got %h want 0", r); end
    endtask

    function automatic logic [31:0] pick_val();
        logic [31:0] edges [6] = '{32'h0, 32'h1, 32'hffffffff, 32'h7fffffff, 32'h80000000, 32'h2};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    task automatic test_random();
        logic [4:0]  pool [22] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                   5'd10, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22,
                                   5'd23, 5'd11, 5'd25, 5'd31};
        logic [31:0] a, b, r, xr; logic [4:0] o; logic e, v, xv; int lat, bc, xl;
        for (int i = 0; i < 80; i++) begin
            o = pool[$urandom_range(0, 21)];
            a = pick_val();
            b = ($urandom_range(0, 7) == 0) ? a : pick_val();
            run_op(o, a, b, r, e, v, lat, bc, xr, xv, xl);
            total++;
            if (r !== xr || v !== xv) begin
                bad++; $display("FAIL rand[%0d] op %0d a %h b %h got %h/%b want %h/%b", i, o, a, b, r, v, xr, xv);
            end
            total++;
            if (e !== (a == b)) begin bad++; $display("FAIL rand_eq[%0d] got %b want %b", i, e, (a == b)); end
            total++;
            if (lat !== xl) begin bad++; $display("FAIL rand_lat[%0d] op %0d got %0d want %0d", i, o, lat, xl); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] xr, a, b; logic [4:0] o; logic xv; int xl;
        logic [31:0] pend_r; logic pend_v;
        pend_r = 32'h0; pend_v = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            if (i > 0) begin
                total++;
                if (out_valid !== 1'b1 || out !== pend_r || ovf !== pend_v || in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b[%0d] v %b out %h ovf %b rdy %b want 1 %h %b 1",
                             i, out_valid, out, ovf, in_ready, pend_r, pend_v);
                end
            end
            if (i < 12) begin
                o = 5'($urandom_range(0, 10));
                a = pick_val();
                b = pick_val();
                ref_model(o, a, b, xr, xv, xl);
                pend_r = xr; pend_v = xv;
                in_valid = 1'b1; op = o; in1 = a; in2 = b;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_hilo_reset();
        test_add_ovf();
        test_mult();
        test_div();
        test_backpressure();
        test_flush();
        test_reset_mid_mult();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
